// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit over a single-port sync-read DMEM, plus the PIO register block.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned accesses respond with an error instead of splitting.
module lsu_mc #(
   parameter int DMEM_AW = 9,
   parameter int LEDR_W  = 17,
   parameter int LEDG_W  = 8,
   parameter int SW_SYNC = 2
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic [31:0]      i_lsu_addr,
   input  logic             i_lsu_wren,
   input  logic [1:0]       i_lsu_size,
   input  logic             i_lsu_signed,
   input  logic [31:0]      i_st_data,
   output logic             o_rsp_valid,
   output logic [31:0]      o_ld_data,
   output logic             o_rsp_err,
   output logic [31:0]      o_io_ledr,
   output logic [31:0]      o_io_ledg,
   output logic [31:0]      o_io_lcd,
   output logic [7:0][6:0]  o_io_hex,
   input  logic [31:0]      i_io_sw
);

   localparam logic [31:0] A_LEDR = 32'h1000_0000;
   localparam logic [31:0] A_LEDG = 32'h1000_1000;
   localparam logic [31:0] A_HEX0 = 32'h1000_2000;
   localparam logic [31:0] A_HEX4 = 32'h1000_3000;
   localparam logic [31:0] A_LCD  = 32'h1000_4000;
   localparam logic [31:0] A_SW   = 32'h1001_0000;

   typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_t;

   state_t state, state_nx;

   logic [31:0]           addr_q, st_q, lo_q, ld_q, rsp_data;
   logic [1:0]            size_q;
   logic                  wren_q, signed_q, err_q, mis_in;
   logic                  is_dmem, crossing;
   logic [1:0]            off;
   logic [3:0]            lane_mask;
   logic [7:0]            be8;
   logic [63:0]           sd64;
   logic                  mem_en, mem_we;
   logic [3:0]            mem_be;
   logic [31:0]           mem_wdata, mem_rdata;
   logic [DMEM_AW-1:0]    mem_addr, word0;
   logic [31:0]           dmem [2**DMEM_AW];
   logic [LEDR_W-1:0]     ledr_q;
   logic [LEDG_W-1:0]     ledg_q;
   logic [1:0][31:0]      seg_q;
   logic [31:0]           lcd_q;
   logic [SW_SYNC-1:0][31:0] sw_ff;
   logic [31:0]           w, ext, pio_rd;

   function automatic logic f_crossing(input logic [31:0] a, input logic [1:0] s);
      return (a[31:DMEM_AW+2] == '0) &&
             ((s[1] && a[1:0] != 2'd0) || (s == 2'b01 && a[1:0] == 2'd3));
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   function automatic logic f_misalign(input logic [31:0] a, input logic [1:0] s);
      return f_crossing(a, s) || (s == 2'b01 && a[0]);
   endfunction
   assign mis_in = f_misalign(i_lsu_addr, i_lsu_size);
`else
   assign mis_in = 1'b0;
`endif

   assign off       = addr_q[1:0];
   assign is_dmem   = (addr_q[31:DMEM_AW+2] == '0);
   assign crossing  = f_crossing(addr_q, size_q);
   assign lane_mask = size_q[1] ? 4'hF : (size_q[0] ? 4'h3 : 4'h1);
   assign be8       = {4'b0, lane_mask} << off;
   assign sd64      = {32'b0, st_q} << {off, 3'b000};
   assign word0     = addr_q[DMEM_AW+1:2];

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) state <= S_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      o_req_ready = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_be      = 4'b0;
      mem_wdata   = 32'b0;
      mem_addr    = word0;
      case (state)
         S_IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) state_nx = mis_in ? S_RESP : S_BEAT0;
         end
         S_BEAT0: begin
            mem_en    = is_dmem;
            mem_we    = wren_q;
            mem_be    = be8[3:0];
            mem_wdata = sd64[31:0];
            state_nx  = crossing ? S_BEAT1 : S_RESP;
         end
         S_BEAT1: begin
            mem_en    = 1'b1;
            mem_we    = wren_q;
            mem_be    = be8[7:4];
            mem_wdata = sd64[63:32];
            mem_addr  = word0 + 1'b1;
            state_nx  = S_RESP;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // DMEM is deliberately not reset; the read register returns the pre-write word.
   always_ff @(posedge i_clk) begin
      if (mem_en) begin
         if (mem_we)
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) dmem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         mem_rdata <= dmem[mem_addr];
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         addr_q   <= '0;
         st_q     <= '0;
         size_q   <= '0;
         wren_q   <= 1'b0;
         signed_q <= 1'b0;
         err_q    <= 1'b0;
         lo_q     <= '0;
         ld_q     <= '0;
      end else begin
         if (state == S_IDLE && i_req_valid) begin
            addr_q   <= i_lsu_addr;
            st_q     <= i_st_data;
            size_q   <= i_lsu_size;
            wren_q   <= i_lsu_wren;
            signed_q <= i_lsu_signed;
            err_q    <= mis_in;
         end
         if (state == S_BEAT1) lo_q <= mem_rdata;
         if (state == S_RESP)  ld_q <= rsp_data;
      end
   end

   // PIO stores take the whole register at the end of BEAT0 regardless of size.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         ledr_q <= '0;
         ledg_q <= '0;
         seg_q  <= '0;
         lcd_q  <= '0;
         sw_ff  <= '0;
      end else begin
         sw_ff <= {sw_ff[SW_SYNC-2:0], i_io_sw};
         if (state == S_BEAT0 && wren_q) begin
            case (addr_q)
               A_LEDR:  ledr_q   <= st_q[LEDR_W-1:0];
               A_LEDG:  ledg_q   <= st_q[LEDG_W-1:0];
               A_HEX0:  seg_q[0] <= st_q;
               A_HEX4:  seg_q[1] <= st_q;
               A_LCD:   lcd_q    <= st_q;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      w = 32'(((crossing ? {mem_rdata, lo_q} : {32'b0, mem_rdata})) >> {off, 3'b000});
      case (size_q)
         2'b00:   ext = {{24{signed_q & w[7]}}, w[7:0]};
         2'b01:   ext = {{16{signed_q & w[15]}}, w[15:0]};
         default: ext = w;
      endcase
      case (addr_q)
         A_LEDR:  pio_rd = o_io_ledr;
         A_LEDG:  pio_rd = o_io_ledg;
         A_HEX0:  pio_rd = seg_q[0];
         A_HEX4:  pio_rd = seg_q[1];
         A_LCD:   pio_rd = lcd_q;
         A_SW:    pio_rd = sw_ff[SW_SYNC-1];
         default: pio_rd = 32'b0;
      endcase
      if (wren_q || err_q) rsp_data = 32'b0;
      else if (is_dmem)    rsp_data = ext;
      else                 rsp_data = pio_rd;
   end

   assign o_rsp_valid = (state == S_RESP);
   assign o_rsp_err   = (state == S_RESP) && err_q;
   assign o_ld_data   = (state == S_RESP) ? rsp_data : ld_q;
   assign o_io_ledr   = {{(32-LEDR_W){1'b0}}, ledr_q};
   assign o_io_ledg   = {{(32-LEDG_W){1'b0}}, ledg_q};
   assign o_io_lcd    = {lcd_q[31], 20'b0, lcd_q[10:0]};

   always_comb begin
      for (int k = 0; k < 8; k++) o_io_hex[k] = seg_q[k/4][8*(k%4) +: 7];
   end

endmodule

// File: tb/tb_lsu_mc.sv
// Directed bench for lsu_mc: vector table of load/store transactions plus a reset-abort sequence.
module tb_lsu_mc;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [31:0]      lsu_addr;
   logic             lsu_wren;
   logic [1:0]       lsu_size;
   logic             lsu_signed;
   logic [31:0]      st_data;
   logic             rsp_valid;
   logic [31:0]      ld_data;
   logic             rsp_err;
   logic [31:0]      io_ledr, io_ledg, io_lcd, io_sw;
   logic [7:0][6:0]  io_hex;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] data;
      logic [31:0] ld;
      int          lat;
      logic [31:0] tld;
      bit          tchk;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   lsu_mc dut (
      .i_clk        (clk),
      .i_reset      (rst_n),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_lsu_addr   (lsu_addr),
      .i_lsu_wren   (lsu_wren),
      .i_lsu_size   (lsu_size),
      .i_lsu_signed (lsu_signed),
      .i_st_data    (st_data),
      .o_rsp_valid  (rsp_valid),
      .o_ld_data    (ld_data),
      .o_rsp_err    (rsp_err),
      .o_io_ledr    (io_ledr),
      .o_io_ledg    (io_ledg),
      .o_io_lcd     (io_lcd),
      .o_io_hex     (io_hex),
      .i_io_sw      (io_sw)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [31:0] a, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] d, input logic [31:0] ld, input int lat,
                          input logic [31:0] tld, input bit tchk);
      vec_t v;
      v.addr = a; v.wr = wr; v.size = sz; v.sgn = sg; v.data = d;
      v.ld = ld; v.lat = lat; v.tld = tld; v.tchk = tchk;
      vecs.push_back(v);
   endtask

   // Bench-side misalignment rule used only for the trap build.
   function automatic bit is_mis(input logic [31:0] a, input logic [1:0] sz);
      bit dm;
      dm = (a < 32'h800);
      return (sz == 2'b01 && a[0]) || (dm && sz[1] && a[1:0] != 2'd0) ||
             (dm && sz == 2'b01 && a[1:0] == 2'd3);
   endfunction

   task automatic applyStimulus(input vec_t v, output int lat, output logic [31:0] ld,
                                output logic err, output bit ok);
      int n;
      @(negedge clk);
      req_valid = 1'b1; lsu_addr = v.addr; lsu_wren = v.wr;
      lsu_size = v.size; lsu_signed = v.sgn; st_data = v.data;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      ok = 1'b0; lat = 0; ld = 'x; err = 1'bx;
      if (!req_ready) begin
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      ok  = rsp_valid;
      ld  = ld_data;
      err = rsp_err;
      @(negedge clk);
      checkOutput("rsp pulse width", {31'b0, rsp_valid}, 32'h0);
   endtask

   initial begin
      int          lat;
      logic [31:0] ld;
      logic        err;
      bit          ok, seen;
      vec_t        v;

      rst_n = 1'b0; req_valid = 1'b0; lsu_addr = '0; lsu_wren = 1'b0;
      lsu_size = '0; lsu_signed = 1'b0; st_data = '0; io_sw = 32'h5;

      //       addr          wr  sz     sg  data          ld            lat tld           tchk
      add_vec(32'h0000_0010, 1, 2'b10, 0, 32'hDEADBEEF, 32'h0,        2, 32'h0,        1);
      add_vec(32'h0000_0010, 0, 2'b10, 0, 32'h0,        32'hDEADBEEF, 2, 32'hDEADBEEF, 1);
      add_vec(32'h0000_0011, 1, 2'b10, 0, 32'h11223344, 32'h0,        3, 32'h0,        1);
      add_vec(32'h0000_0011, 0, 2'b10, 0, 32'h0,        32'h11223344, 3, 32'h0,        1);
      add_vec(32'h0000_0010, 0, 2'b10, 0, 32'h0,        32'h223344EF, 2, 32'hDEADBEEF, 1);
      add_vec(32'h0000_0014, 0, 2'b00, 0, 32'h0,        32'h11,       2, 32'h0,        0);
      add_vec(32'h0000_0003, 1, 2'b00, 0, 32'h80,       32'h0,        2, 32'h0,        1);
      add_vec(32'h0000_0003, 0, 2'b00, 1, 32'h0,        32'hFFFFFF80, 2, 32'hFFFFFF80, 1);
      add_vec(32'h0000_0003, 0, 2'b00, 0, 32'h0,        32'h00000080, 2, 32'h00000080, 1);
      add_vec(32'h0000_0002, 1, 2'b00, 0, 32'h5A,       32'h0,        2, 32'h0,        1);
      add_vec(32'h0000_0002, 0, 2'b01, 1, 32'h0,        32'hFFFF805A, 2, 32'hFFFF805A, 1);
      add_vec(32'h0000_0001, 1, 2'b01, 0, 32'h1234,     32'h0,        2, 32'h0,        1);
      add_vec(32'h0000_0001, 0, 2'b01, 0, 32'h0,        32'h1234,     2, 32'h0,        1);
      add_vec(32'h0000_0002, 0, 2'b00, 0, 32'h0,        32'h12,       2, 32'h5A,       1);
      add_vec(32'h0000_07FF, 1, 2'b01, 0, 32'hABCD,     32'h0,        3, 32'h0,        1);
      add_vec(32'h0000_0000, 0, 2'b00, 0, 32'h0,        32'hAB,       2, 32'h0,        0);
      add_vec(32'h0000_07FF, 0, 2'b01, 0, 32'h0,        32'hABCD,     3, 32'h0,        1);
      add_vec(32'h1000_0000, 1, 2'b00, 0, 32'hFFFFFFFF, 32'h0,        2, 32'h0,        1);
      add_vec(32'h1000_2000, 1, 2'b10, 0, 32'h7F7F7F7F, 32'h0,        2, 32'h0,        1);
      add_vec(32'h1000_4000, 1, 2'b10, 0, 32'hFFFFFFFF, 32'h0,        2, 32'h0,        1);
      add_vec(32'h1000_4000, 0, 2'b10, 0, 32'h0,        32'hFFFFFFFF, 2, 32'hFFFFFFFF, 1);
      add_vec(32'h1001_0000, 0, 2'b10, 0, 32'h0,        32'h5,        2, 32'h5,        1);
      add_vec(32'h2000_0000, 1, 2'b10, 0, 32'h12345678, 32'h0,        2, 32'h0,        1);
      add_vec(32'h2000_0000, 0, 2'b10, 0, 32'h0,        32'h0,        2, 32'h0,        1);
      add_vec(32'h1000_1000, 1, 2'b10, 0, 32'h00000123, 32'h0,        2, 32'h0,        1);

      repeat (3) @(negedge clk);
      checkOutput("reset ready",  {31'b0, req_ready}, 32'h1);
      checkOutput("reset rsp",    {31'b0, rsp_valid}, 32'h0);
      checkOutput("reset ld",     ld_data,            32'h0);
      checkOutput("reset err",    {31'b0, rsp_err},   32'h0);
      checkOutput("reset ledr",   io_ledr,            32'h0);
      checkOutput("reset lcd",    io_lcd,             32'h0);
      checkOutput("reset hex7",   {25'b0, io_hex[7]}, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         if (TRAP && !v.tchk) continue;
         applyStimulus(v, lat, ld, err, ok);
         if (!ok) begin
            checkOutput($sformatf("v%0d timeout", i), 32'h0, 32'h1);
            continue;
         end
         if (TRAP && is_mis(v.addr, v.size)) begin
            checkOutput($sformatf("v%0d lat", i), lat, 32'd1);
            checkOutput($sformatf("v%0d err", i), {31'b0, err}, 32'h1);
            checkOutput($sformatf("v%0d ld", i),  ld, 32'h0);
         end else begin
            checkOutput($sformatf("v%0d lat", i), lat, v.lat);
            checkOutput($sformatf("v%0d err", i), {31'b0, err}, 32'h0);
            checkOutput($sformatf("v%0d ld", i),  ld, TRAP ? v.tld : v.ld);
         end
      end

      checkOutput("ledr out", io_ledr, 32'h0001_FFFF);
      checkOutput("ledg out", io_ledg, 32'h0000_0023);
      checkOutput("lcd out",  io_lcd,  32'h8000_07FF);
      for (int k = 0; k < 4; k++)
         checkOutput($sformatf("hex%0d", k), {25'b0, io_hex[k]}, 32'h7F);
      checkOutput("hex4", {25'b0, io_hex[4]}, 32'h0);

`ifndef LSU_MISALIGN_TRAP_EN
      // Crossing store aborted by reset during its second beat.
      v = vecs[0]; v.addr = 32'h20; v.data = 32'h0;
      applyStimulus(v, lat, ld, err, ok);
      v.addr = 32'h24;
      applyStimulus(v, lat, ld, err, ok);
      @(negedge clk);
      req_valid = 1'b1; lsu_addr = 32'h21; lsu_wren = 1'b1;
      lsu_size = 2'b10; lsu_signed = 1'b0; st_data = 32'hCAFEF00D;
      checkOutput("abort ready", {31'b0, req_ready}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      seen = rsp_valid;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         seen = seen | rsp_valid;
      end
      checkOutput("abort no rsp", {31'b0, seen}, 32'h0);
      checkOutput("abort ready after", {31'b0, req_ready}, 32'h1);
      checkOutput("abort ledr", io_ledr, 32'h0);
      checkOutput("abort hex0", {25'b0, io_hex[0]}, 32'h0);
      v = vecs[1]; v.addr = 32'h20;
      applyStimulus(v, lat, ld, err, ok);
      checkOutput("abort beat0 word", ld, 32'hFEF00D00);
      v.addr = 32'h24;
      applyStimulus(v, lat, ld, err, ok);
      checkOutput("abort beat1 word", ld, 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
